// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter sharing one carry-extended adder among NUM_REQ requesters,
// with a one-entry registered result stage tagged by requester ID.
module add_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W:0]           rsp_sum,
    output logic [ID_W-1:0]           rsp_id,
    output logic [15:0]               op_count
);
    logic [ID_W-1:0]    last, gnt_id, idx;
    logic [NUM_REQ-1:0] gnt;
    logic               found, slot_free, fire;
    logic [DATA_W-1:0]  op1_sel, op2_sel;

    // Scan starts just after the last accepted requester and wraps.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

    assign slot_free = !rsp_valid || rsp_ready;
    assign req_ready = gnt & {NUM_REQ{slot_free && !rst}};
    assign fire      = |(req_valid & req_ready);
    assign op1_sel   = req_op1[int'(gnt_id)*DATA_W +: DATA_W];
    assign op2_sel   = req_op2[int'(gnt_id)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            op_count  <= '0;
            last      <= ID_W'(NUM_REQ - 1);
        end else if (fire) begin
            rsp_sum   <= {1'b0, op1_sel} + {1'b0, op2_sel};
            rsp_id    <= gnt_id;
            rsp_valid <= 1'b1;
            last      <= gnt_id;
            op_count  <= op_count + 16'd1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule
